// File: rtl/xeng_vacc.sv
// X-engine vector accumulator: sums per-baseline Stokes words over
// acc_len vectors and streams each finished integration out widened.
module xeng_vacc #(
  parameter int BITWIDTH            = 4,
  parameter int P_FACTOR_BITS       = 0,
  parameter int SERIAL_ACC_LEN_BITS = 7,
  parameter int VEC_LEN             = 36,
  parameter int ACC_LEN_BITS        = 8,
  localparam int CW        = 2*BITWIDTH+1+P_FACTOR_BITS+SERIAL_ACC_LEN_BITS,
  localparam int IN_WIDTH  = 8*CW,
  localparam int OW        = CW+ACC_LEN_BITS,
  localparam int OUT_WIDTH = 8*OW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sync,
  input  logic [ACC_LEN_BITS-1:0] acc_len,
  input  logic [IN_WIDTH-1:0]     acc_in,
  input  logic                    valid_in,
  output logic [OUT_WIDTH-1:0]    dout,
  output logic                    valid_out,
  output logic                    first_out,
  output logic                    last_out,
  output logic [15:0]             int_cnt
);

  localparam int AW = $clog2(VEC_LEN);
  localparam logic [AW-1:0] WLAST = AW'(VEC_LEN-1);
  localparam logic [ACC_LEN_BITS-1:0] LEN1 = ACC_LEN_BITS'(1);

  logic [AW-1:0]           word_ctr;
  logic [ACC_LEN_BITS-1:0] vec_ctr;
  logic [ACC_LEN_BITS-1:0] len_reg;
  logic [ACC_LEN_BITS-1:0] cur_len;
  logic                    int_start;
  logic                    word_last;
  logic                    vec_last;

  logic                    s1_valid;
  logic [IN_WIDTH-1:0]     s1_in;
  logic [AW-1:0]           s1_addr;
  logic                    s1_first;
  logic                    s1_dump;
  logic                    s1_w0;
  logic                    s1_wl;

  logic [OUT_WIDTH-1:0]    mem [VEC_LEN];
  logic [OUT_WIDTH-1:0]    ram_q;
  logic [OUT_WIDTH-1:0]    sum;

  // Length in force for the current word; a new integration picks up acc_len
  always_comb begin
    int_start = (word_ctr == '0) && (vec_ctr == '0);
    cur_len   = len_reg;
    if (int_start) begin
      cur_len = (acc_len == '0) ? LEN1 : acc_len;
    end
    word_last = (word_ctr == WLAST);
    vec_last  = (vec_ctr == cur_len - LEN1);
  end

  // Word/vector position counters; sync realigns after the current word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_ctr <= '0;
      vec_ctr  <= '0;
      len_reg  <= LEN1;
    end else begin
      if (valid_in) begin
        if (int_start) begin
          len_reg <= cur_len;
        end
        if (word_last) begin
          word_ctr <= '0;
          vec_ctr  <= vec_last ? '0 : vec_ctr + LEN1;
        end else begin
          word_ctr <= word_ctr + AW'(1);
        end
      end
      if (sync) begin
        word_ctr <= '0;
        vec_ctr  <= '0;
      end
    end
  end

  // Stage 0: capture the word, its address and phase alongside the RAM read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_in    <= '0;
      s1_addr  <= '0;
      s1_first <= 1'b0;
      s1_dump  <= 1'b0;
      s1_w0    <= 1'b0;
      s1_wl    <= 1'b0;
    end else begin
      s1_valid <= valid_in;
      if (valid_in) begin
        s1_in    <= acc_in;
        s1_addr  <= word_ctr;
        s1_first <= (vec_ctr == '0);
        s1_dump  <= vec_last;
        s1_w0    <= (word_ctr == '0);
        s1_wl    <= word_last;
      end
    end
  end

  // Stage 1: per-component sign-extend and add the stored partial sum
  for (genvar k = 0; k < 8; k++) begin : g_comp
    logic [OW-1:0] a;
    logic [OW-1:0] b;
    assign a = {{(OW-CW){s1_in[k*CW+CW-1]}}, s1_in[k*CW +: CW]};
    assign b = s1_first ? '0 : ram_q[k*OW +: OW];
    assign sum[k*OW +: OW] = a + b;
  end

  // Accumulation RAM, one-cycle read; dump vector is never written back
  always_ff @(posedge clk) begin
    if (valid_in) begin
      ram_q <= mem[word_ctr];
    end
    if (s1_valid && !s1_dump) begin
      mem[s1_addr] <= sum;
    end
  end

  // Output register and completed-integration counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout      <= '0;
      valid_out <= 1'b0;
      first_out <= 1'b0;
      last_out  <= 1'b0;
      int_cnt   <= '0;
    end else begin
      valid_out <= s1_valid && s1_dump;
      first_out <= s1_valid && s1_dump && s1_w0;
      last_out  <= s1_valid && s1_dump && s1_wl;
      if (s1_valid && s1_dump) begin
        dout <= sum;
        if (s1_wl) begin
          int_cnt <= int_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_xeng_vacc.sv
// Randomised bench for xeng_vacc against an integer integration model.
// Streams are compared record by record including output cycle.
module tb_xeng_vacc;

  localparam int CW    = 16;
  localparam int OW    = 24;
  localparam int VEC   = 36;
  localparam int IN_W  = 8*CW;
  localparam int OUT_W = 8*OW;

  typedef struct packed {
    logic [31:0]      cyc;
    logic             f;
    logic             l;
    logic [OUT_W-1:0] d;
  } rec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sync = 1'b0;
  logic [7:0]       acc_len = 8'd1;
  logic [IN_W-1:0]  acc_in = '0;
  logic             valid_in = 1'b0;
  logic [OUT_W-1:0] dout;
  logic             valid_out;
  logic             first_out;
  logic             last_out;
  logic [15:0]      int_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  rec_t exp_q[$];
  rec_t got_q[$];

  int macc[VEC][8];
  int mw, mv, ml, mcnt;

  xeng_vacc dut (
    .clk(clk), .rst(rst), .sync(sync), .acc_len(acc_len),
    .acc_in(acc_in), .valid_in(valid_in), .dout(dout),
    .valid_out(valid_out), .first_out(first_out),
    .last_out(last_out), .int_cnt(int_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    rec_t r;
    if (!rst && valid_out) begin
      r.cyc = cyc;
      r.f = first_out;
      r.l = last_out;
      r.d = dout;
      got_q.push_back(r);
    end
  end

  task automatic model_reset();
    mw = 0; mv = 0; ml = 1; mcnt = 0;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic model_word(input logic [IN_W-1:0] d);
    bit f, dp;
    int s;
    rec_t r;
    if (mw == 0 && mv == 0) ml = (acc_len == 0) ? 1 : int'(acc_len);
    f = (mv == 0);
    dp = (mv == ml - 1);
    for (int k = 0; k < 8; k++) begin
      s = (f ? 0 : macc[mw][k]) + int'($signed(d[k*CW +: CW]));
      macc[mw][k] = s;
      r.d[k*OW +: OW] = s[OW-1:0];
    end
    if (dp) begin
      r.cyc = cyc + 2;
      r.f = (mw == 0);
      r.l = (mw == VEC-1);
      exp_q.push_back(r);
      if (mw == VEC-1) mcnt++;
    end
    mw++;
    if (mw == VEC) begin
      mw = 0;
      mv++;
      if (mv == ml) mv = 0;
    end
  endtask

  task automatic drive(input logic v, input logic [IN_W-1:0] d, input logic s);
    @(negedge clk);
    valid_in = v;
    acc_in = d;
    sync = s;
    if (v) model_word(d);
    if (s) begin mw = 0; mv = 0; end
  endtask

  function automatic logic [IN_W-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic flush();
    repeat (4) drive(1'b0, '0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({dout, valid_out, first_out, last_out, int_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b f=%b l=%b cnt=%0d d=%h exp all zero",
               valid_out, first_out, last_out, int_cnt, dout);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_len1();
    rec_t g, e;
    logic [IN_W-1:0] d;
    acc_len = 8'd1;
    for (int k = 0; k < VEC; k++) begin
      d = {8{16'(k)}};
      drive(1'b1, d, 1'b0);
    end
    flush();
    checks++;
    if (got_q.size() != VEC) begin
      errors++;
      $display("FAIL len1_count got %0d exp %0d", got_q.size(), VEC);
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL len1_word got c=%0d f=%b l=%b d=%h exp c=%0d f=%b l=%b d=%h",
                 g.cyc, g.f, g.l, g.d, e.cyc, e.f, e.l, e.d);
      end
    end
    checks++;
    if (int_cnt !== 16'd1) begin
      errors++;
      $display("FAIL len1_int_cnt got %0d exp 1", int_cnt);
    end
  endtask

  task automatic test_len4_neg();
    rec_t g, e;
    acc_len = 8'd4;
    repeat (3*VEC) drive(1'b1, {8{-16'sd3}}, 1'b0);
    flush();
    checks++;
    if (got_q.size() != 0) begin
      errors++;
      $display("FAIL len4_early_output got %0d words exp 0", got_q.size());
    end
    repeat (VEC) drive(1'b1, {8{-16'sd3}}, 1'b0);
    flush();
    checks++;
    if (got_q.size() != VEC || exp_q.size() != VEC) begin
      errors++;
      $display("FAIL len4_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e || g.d !== {8{24'hFFFFF4}}) begin
        errors++;
        $display("FAIL len4_word got c=%0d f=%b l=%b d=%h exp c=%0d f=%b l=%b d=%h",
                 g.cyc, g.f, g.l, g.d, e.cyc, e.f, e.l, e.d);
      end
    end
    checks++;
    if (int_cnt !== 16'(mcnt)) begin
      errors++;
      $display("FAIL len4_int_cnt got %0d exp %0d", int_cnt, mcnt);
    end
  endtask

  task automatic test_len255();
    rec_t g, e;
    logic [15:0] c0;
    c0 = int_cnt;
    acc_len = 8'd255;
    repeat (255*VEC - 1) drive(1'b1, {8{16'sd32767}}, 1'b0);
    flush();
    checks++;
    if (int_cnt !== c0) begin
      errors++;
      $display("FAIL len255_early_cnt got %0d exp %0d", int_cnt, c0);
    end
    drive(1'b1, {8{16'sd32767}}, 1'b0);
    flush();
    checks++;
    if (got_q.size() != VEC) begin
      errors++;
      $display("FAIL len255_count got %0d exp %0d", got_q.size(), VEC);
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e || g.d !== {8{24'd8355585}}) begin
        errors++;
        $display("FAIL len255_word got c=%0d f=%b l=%b d=%h exp c=%0d f=%b l=%b d=%h",
                 g.cyc, g.f, g.l, g.d, e.cyc, e.f, e.l, e.d);
      end
    end
    checks++;
    if (int_cnt !== c0 + 16'd1) begin
      errors++;
      $display("FAIL len255_int_cnt got %0d exp %0d", int_cnt, c0 + 16'd1);
    end
  endtask

  task automatic test_gaps();
    rec_t g, e;
    acc_len = 8'd3;
    for (int i = 0; i < 3*VEC; i++) begin
      while ($urandom_range(1) == 1) drive(1'b0, rnd(), 1'b0);
      drive(1'b1, rnd(), 1'b0);
    end
    flush();
    checks++;
    if (got_q.size() != VEC || exp_q.size() != VEC) begin
      errors++;
      $display("FAIL gaps_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL gaps_word got c=%0d f=%b l=%b d=%h exp c=%0d f=%b l=%b d=%h",
                 g.cyc, g.f, g.l, g.d, e.cyc, e.f, e.l, e.d);
      end
    end
    checks++;
    if (int_cnt !== 16'(mcnt)) begin
      errors++;
      $display("FAIL gaps_int_cnt got %0d exp %0d", int_cnt, mcnt);
    end
  endtask

  task automatic test_sync();
    rec_t g, e;
    acc_len = 8'd4;
    repeat (50) drive(1'b1, rnd(), 1'b0);
    drive(1'b0, '0, 1'b1);
    repeat (4*VEC) drive(1'b1, rnd(), 1'b0);
    flush();
    checks++;
    if (got_q.size() != VEC || exp_q.size() != VEC) begin
      errors++;
      $display("FAIL sync_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL sync_word got c=%0d f=%b l=%b d=%h exp c=%0d f=%b l=%b d=%h",
                 g.cyc, g.f, g.l, g.d, e.cyc, e.f, e.l, e.d);
      end
    end
  endtask

  task automatic test_len_change();
    rec_t g, e;
    acc_len = 8'd2;
    repeat (VEC) drive(1'b1, rnd(), 1'b0);
    acc_len = 8'd5;
    repeat (VEC) drive(1'b1, rnd(), 1'b0);
    flush();
    checks++;
    if (got_q.size() != VEC) begin
      errors++;
      $display("FAIL lenchg_first_dump got %0d exp %0d", got_q.size(), VEC);
    end
    repeat (4*VEC) drive(1'b1, rnd(), 1'b0);
    flush();
    checks++;
    if (got_q.size() != VEC) begin
      errors++;
      $display("FAIL lenchg_no_early got %0d exp %0d", got_q.size(), VEC);
    end
    repeat (VEC) drive(1'b1, rnd(), 1'b0);
    flush();
    checks++;
    if (got_q.size() != 2*VEC || exp_q.size() != 2*VEC) begin
      errors++;
      $display("FAIL lenchg_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL lenchg_word got c=%0d f=%b l=%b d=%h exp c=%0d f=%b l=%b d=%h",
                 g.cyc, g.f, g.l, g.d, e.cyc, e.f, e.l, e.d);
      end
    end
    checks++;
    if (int_cnt !== 16'(mcnt)) begin
      errors++;
      $display("FAIL lenchg_int_cnt got %0d exp %0d", int_cnt, mcnt);
    end
  endtask

  task automatic test_async_rst();
    rec_t g, e;
    acc_len = 8'd1;
    repeat (10) drive(1'b1, rnd(), 1'b0);
    @(posedge clk);
    #2;
    valid_in = 1'b0;
    checks++;
    if (valid_out !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre_valid got %b exp 1", valid_out);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({dout, valid_out, first_out, last_out, int_cnt} !== '0) begin
      errors++;
      $display("FAIL arst_outputs got v=%b f=%b l=%b cnt=%0d d=%h exp all zero",
               valid_out, first_out, last_out, int_cnt, dout);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    acc_len = 8'd2;
    repeat (2*VEC) drive(1'b1, rnd(), 1'b0);
    flush();
    checks++;
    if (got_q.size() != VEC || exp_q.size() != VEC) begin
      errors++;
      $display("FAIL arst_after_count got %0d exp %0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL arst_after_word got c=%0d f=%b l=%b d=%h exp c=%0d f=%b l=%b d=%h",
                 g.cyc, g.f, g.l, g.d, e.cyc, e.f, e.l, e.d);
      end
    end
    checks++;
    if (int_cnt !== 16'd1) begin
      errors++;
      $display("FAIL arst_int_cnt got %0d exp 1", int_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_len1();
    test_len4_neg();
    test_len255();
    test_gaps();
    test_sync();
    test_len_change();
    test_async_rst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
